// File: rtl/enemy_spawner_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the whack-a-mole game blocks: spawner FSM state
// encoding, keypad/board cell codes (shared with the sprite renderers and the
// keyboard decoder), and the spawn LFSR seed/taps plus its step function.
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2,
        ST_HIT  = 2'd3
    } state_e;

    // Board cells, row-major over the Q/W/E, A/S/D, Z/X/C keypad.
    localparam logic [3:0] POS_NONE = 4'd0;
    localparam logic [3:0] KEY_Q    = 4'd1;
    localparam logic [3:0] KEY_W    = 4'd2;
    localparam logic [3:0] KEY_E    = 4'd3;
    localparam logic [3:0] KEY_A    = 4'd4;
    localparam logic [3:0] KEY_S    = 4'd5;
    localparam logic [3:0] KEY_D    = 4'd6;
    localparam logic [3:0] KEY_Z    = 4'd7;
    localparam logic [3:0] KEY_X    = 4'd8;
    localparam logic [3:0] KEY_C    = 4'd9;

    // x^8+x^6+x^5+x^4+1, shifting towards the MSB: feedback from bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/enemy_spawner_lfsr_cell_pick.sv
// ---------------------------------------------------------------------------
// lfsr_cell_pick
// Free-running 8-bit Fibonacci LFSR mapped onto cells 1..9, with the previous
// spawned cell remembered so the same cell never comes up twice in a row.
// Ports:
//   clk     in  : system clock
//   rst_n   in  : asynchronous active-low reset
//   i_take  in  : strobe, the current o_cell is being spawned
//   o_cell  out : candidate cell 1..9 for the next spawn
// ---------------------------------------------------------------------------
module lfsr_cell_pick
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_take,
    output logic [3:0] o_cell
);

    logic [7:0] r_lfsr;
    logic [3:0] r_prev;
    logic [3:0] w_cand;

    // Map LFSR state to 1..9; bump to the next cell (9 wraps to 1) on a repeat.
    always_comb begin
        w_cand = 4'(r_lfsr % 8'd9) + 4'd1;
        if (w_cand == r_prev) begin
            o_cell = (w_cand == KEY_C) ? KEY_Q : (w_cand + 4'd1);
        end else begin
            o_cell = w_cand;
        end
    end

    // LFSR advances every cycle; previous cell is captured on each spawn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
            r_prev <= POS_NONE;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
            if (i_take) begin
                r_prev <= o_cell;
            end else begin
                r_prev <= r_prev;
            end
        end
    end

endmodule

// File: rtl/enemy_spawner.sv
// ---------------------------------------------------------------------------
// enemy_spawner
// Game controller for the 3x3 board: spawns an enemy on a pseudo-random cell,
// keeps it up for a bounded lifetime, scores keypad strikes against it, shows
// the hit for a while, then waits a gap before the next spawn.
// Ports:
//   clk       in     : system clock
//   rst       in     : asynchronous active-low reset
//   run       in     : level, high while the game runs
//   key_valid in     : one-cycle keypad strobe
//   key_code  in [4] : struck cell 1..9, anything else ignored
//   pos       out[4] : active enemy cell, 0 = none
//   hit       out    : high while a struck enemy is displayed
//   hit_cnt   out[8] : successful strikes, saturating
//   miss_cnt  out[8] : expired enemies, saturating
// Build option: ENEMY_SPEEDUP_EN shortens the enemy lifetime by one tick for
// every 8 hits (floored at one tick), sampled when the enemy appears.
// ---------------------------------------------------------------------------
module enemy_spawner
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 2_500_000,
    parameter int unsigned LIFE_TICKS = 25,
    parameter int unsigned HIT_TICKS  = 8,
    parameter int unsigned GAP_TICKS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] pos,
    output logic       hit,
    output logic [7:0] hit_cnt,
    output logic [7:0] miss_cnt
);

    localparam logic [31:0] DIV_MAX  = 32'(TICK_DIV - 32'd1);
    localparam logic [31:0] LIFE_U   = 32'(LIFE_TICKS);
    localparam logic [31:0] HIT_MAX  = 32'(HIT_TICKS - 32'd1);
    localparam logic [31:0] GAP_MAX  = 32'(GAP_TICKS - 32'd1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_div;
    logic [31:0] r_tcnt;
    logic [3:0]  r_pos;
    logic        r_hit;
    logic [7:0]  r_hit_cnt;
    logic [7:0]  r_miss_cnt;

    logic [3:0]  w_cell;
    logic [3:0]  w_pos_nxt;
    logic        w_hit_nxt;
    logic        w_take;
    logic        w_inc_hit;
    logic        w_inc_miss;
    logic        w_clr_cnt;
    logic        w_tick;
    logic        w_enter;
    logic        w_key_match;
    logic [31:0] w_life_max;

    lfsr_cell_pick u_pick (
        .clk    (clk),
        .rst_n  (rst),
        .i_take (w_take),
        .o_cell (w_cell)
    );

`ifdef ENEMY_SPEEDUP_EN
    logic [31:0] r_life;
    logic [31:0] w_dec;
    logic [31:0] w_life_new;

    // Lifetime shrinks by hit_cnt/8 ticks but never below one tick.
    always_comb begin
        w_dec = {27'd0, r_hit_cnt[7:3]};
        if (w_dec >= LIFE_U) begin
            w_life_new = 32'd1;
        end else begin
            w_life_new = LIFE_U - w_dec;
        end
        w_life_max = r_life - 32'd1;
    end

    // Lifetime is latched as the enemy appears so it stays fixed while shown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_life <= LIFE_U;
        end else if (w_take) begin
            r_life <= w_life_new;
        end else begin
            r_life <= r_life;
        end
    end
`else
    assign w_life_max = LIFE_U - 32'd1;
`endif

    assign w_tick      = (r_div == DIV_MAX);
    assign w_enter     = (w_state_nxt != r_state);
    assign w_key_match = key_valid && (key_code >= KEY_Q) && (key_code <= KEY_C)
                         && (key_code == r_pos);

    // Next-state and next-output decode; run low overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_hit_nxt   = r_hit;
        w_take      = 1'b0;
        w_inc_hit   = 1'b0;
        w_inc_miss  = 1'b0;
        w_clr_cnt   = 1'b0;
        if (!run) begin
            w_state_nxt = ST_IDLE;
            w_pos_nxt   = POS_NONE;
            w_hit_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_GAP;
                    w_pos_nxt   = POS_NONE;
                    w_hit_nxt   = 1'b0;
                    w_clr_cnt   = 1'b1;
                end
                ST_GAP: begin
                    if (w_tick && (r_tcnt == GAP_MAX)) begin
                        w_state_nxt = ST_SHOW;
                        w_pos_nxt   = w_cell;
                        w_take      = 1'b1;
                    end else begin
                        w_pos_nxt   = POS_NONE;
                    end
                end
                ST_SHOW: begin
                    // A strike on the expiry edge still counts as a hit.
                    if (w_key_match) begin
                        w_state_nxt = ST_HIT;
                        w_hit_nxt   = 1'b1;
                        w_inc_hit   = 1'b1;
                    end else if (w_tick && (r_tcnt == w_life_max)) begin
                        w_state_nxt = ST_GAP;
                        w_pos_nxt   = POS_NONE;
                        w_inc_miss  = 1'b1;
                    end else begin
                        w_pos_nxt   = r_pos;
                    end
                end
                ST_HIT: begin
                    if (w_tick && (r_tcnt == HIT_MAX)) begin
                        w_state_nxt = ST_GAP;
                        w_pos_nxt   = POS_NONE;
                        w_hit_nxt   = 1'b0;
                    end else begin
                        w_hit_nxt   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_pos_nxt   = POS_NONE;
                    w_hit_nxt   = 1'b0;
                end
            endcase
        end
    end

    // State, outputs and tick timing; divider and tick count restart on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pos   <= POS_NONE;
            r_hit   <= 1'b0;
            r_div   <= 32'd0;
            r_tcnt  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_hit   <= w_hit_nxt;
            if (w_enter) begin
                r_div  <= 32'd0;
                r_tcnt <= 32'd0;
            end else if (w_tick) begin
                r_div  <= 32'd0;
                r_tcnt <= r_tcnt + 32'd1;
            end else begin
                r_div  <= r_div + 32'd1;
            end
        end
    end

    // Saturating score counters, cleared when a new game starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= 8'd0;
            r_miss_cnt <= 8'd0;
        end else if (w_clr_cnt) begin
            r_hit_cnt  <= 8'd0;
            r_miss_cnt <= 8'd0;
        end else begin
            if (w_inc_hit && (r_hit_cnt != 8'hFF)) begin
                r_hit_cnt <= r_hit_cnt + 8'd1;
            end else begin
                r_hit_cnt <= r_hit_cnt;
            end
            if (w_inc_miss && (r_miss_cnt != 8'hFF)) begin
                r_miss_cnt <= r_miss_cnt + 8'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt;
            end
        end
    end

    assign pos      = r_pos;
    assign hit      = r_hit;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_enemy_spawner.sv
module tb_enemy_spawner;

    typedef struct packed {
        logic [3:0] pos;
        logic       hit;
        logic [7:0] hc;
        logic [7:0] mc;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] pos;
    logic       hit;
    logic [7:0] hit_cnt;
    logic [7:0] miss_cnt;

    int         checks = 0;
    int         errors = 0;
    snap_t      exp_q[$];
    snap_t      obs_q[$];
    snap_t      e;
    snap_t      o;
    logic [7:0] m_lfsr;
    logic [3:0] last_cell;
    logic [3:0] cur;
    logic [7:0] e_hc;
    logic [7:0] e_mc;
    int         e_life;

    enemy_spawner #(
        .TICK_DIV   (1),
        .LIFE_TICKS (5),
        .HIT_TICKS  (2),
        .GAP_TICKS  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .key_valid (key_valid),
        .key_code  (key_code),
        .pos       (pos),
        .hit       (hit),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, steps every cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 8'hA5;
        else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [3:0] pick(input logic [7:0] l, input logic [3:0] prev);
        logic [3:0] c;
        c = 4'(l % 8'd9) + 4'd1;
        if (c == prev) c = (c == 4'd9) ? 4'd1 : c + 4'd1;
        return c;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'd255) ? 8'd255 : v + 8'd1;
    endfunction

    // One clock of stimulus; the expected outputs after that edge are queued.
    task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] p, input logic h);
        exp_q.push_back('{pos: p, hit: h, hc: e_hc, mc: e_mc});
        @(negedge clk);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        #1;
        obs_q.push_back('{pos: pos, hit: hit, hc: hit_cnt, mc: miss_cnt});
    endtask

    // Remaining two gap cycles, then the spawn edge with the predicted cell.
    task automatic gap_spawn;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        cur       = pick(m_lfsr, last_cell);
        last_cell = cur;
`ifdef ENEMY_SPEEDUP_EN
        e_life = ((e_hc >> 3) >= 8'd5) ? 1 : 5 - int'(e_hc >> 3);
`else
        e_life = 5;
`endif
        drive(1'b0, 4'd0, cur, 1'b0);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({pos, hit, hit_cnt, miss_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL reset: got pos=%0d hit=%0d hit_cnt=%0d miss_cnt=%0d, want all 0",
                     pos, hit, hit_cnt, miss_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_idle: got pos=%0d hit=%0d hc=%0d mc=%0d, want pos=%0d hit=%0d hc=%0d mc=%0d",
                         o.pos, o.hit, o.hc, o.mc, e.pos, e.hit, e.hc, e.mc);
            end
        end
    endtask

    task automatic test_spawn;
        run = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        gap_spawn();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL spawn: got pos=%0d hit=%0d hc=%0d mc=%0d, want pos=%0d hit=%0d hc=%0d mc=%0d",
                         o.pos, o.hit, o.hc, o.mc, e.pos, e.hit, e.hc, e.mc);
            end
        end
    endtask

    task automatic test_hits(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            e_hc = sat_inc(e_hc);
            drive(1'b1, cur, cur, 1'b1);
            drive(1'b0, 4'd0, cur, 1'b1);
            drive(1'b0, 4'd0, 4'd0, 1'b0);
            gap_spawn();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got pos=%0d hit=%0d hc=%0d mc=%0d, want pos=%0d hit=%0d hc=%0d mc=%0d",
                         name, o.pos, o.hit, o.hc, o.mc, e.pos, e.hit, e.hc, e.mc);
            end
        end
    endtask

    task automatic test_miss(input string name);
        logic [3:0] prev;
        repeat (e_life - 1) drive(1'b0, 4'd0, cur, 1'b0);
        e_mc = sat_inc(e_mc);
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        prev = cur;
        gap_spawn();
        checks++;
        if (pos === prev || pos === 4'd0) begin
            errors++;
            $display("FAIL %s_respawn: got pos=%0d, required nonzero and not %0d", name, pos, prev);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got pos=%0d hit=%0d hc=%0d mc=%0d, want pos=%0d hit=%0d hc=%0d mc=%0d",
                         name, o.pos, o.hit, o.hc, o.mc, e.pos, e.hit, e.hc, e.mc);
            end
        end
    endtask

    task automatic test_wrong_key;
        drive(1'b1, cur + 4'd1, cur, 1'b0);
        drive(1'b1, 4'd12, cur, 1'b0);
        repeat (e_life - 3) drive(1'b0, 4'd0, cur, 1'b0);
        e_mc = sat_inc(e_mc);
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        gap_spawn();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wrong_key: got pos=%0d hit=%0d hc=%0d mc=%0d, want pos=%0d hit=%0d hc=%0d mc=%0d",
                         o.pos, o.hit, o.hc, o.mc, e.pos, e.hit, e.hc, e.mc);
            end
        end
    endtask

    task automatic test_expiry_match;
        repeat (e_life - 1) drive(1'b0, 4'd0, cur, 1'b0);
        e_hc = sat_inc(e_hc);
        drive(1'b1, cur, cur, 1'b1);
        drive(1'b0, 4'd0, cur, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        gap_spawn();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL expiry_match: got pos=%0d hit=%0d hc=%0d mc=%0d, want pos=%0d hit=%0d hc=%0d mc=%0d",
                         o.pos, o.hit, o.hc, o.mc, e.pos, e.hit, e.hc, e.mc);
            end
        end
    endtask

    task automatic test_run_drop;
        run = 1'b0;
        drive(1'b1, cur, 4'd0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        run  = 1'b1;
        e_hc = 8'd0;
        e_mc = 8'd0;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        gap_spawn();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL run_drop: got pos=%0d hit=%0d hc=%0d mc=%0d, want pos=%0d hit=%0d hc=%0d mc=%0d",
                         o.pos, o.hit, o.hc, o.mc, e.pos, e.hit, e.hc, e.mc);
            end
        end
    endtask

    task automatic test_reset_mid;
        e_hc = sat_inc(e_hc);
        drive(1'b1, cur, cur, 1'b1);
        rst = 1'b0;
        #2;
        checks++;
        if ({pos, hit, hit_cnt, miss_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid: got pos=%0d hit=%0d hit_cnt=%0d miss_cnt=%0d, want all 0",
                     pos, hit, hit_cnt, miss_cnt);
        end
        e_hc      = 8'd0;
        e_mc      = 8'd0;
        last_cell = 4'd0;
        run       = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        gap_spawn();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid_restart: got pos=%0d hit=%0d hc=%0d mc=%0d, want pos=%0d hit=%0d hc=%0d mc=%0d",
                         o.pos, o.hit, o.hc, o.mc, e.pos, e.hit, e.hc, e.mc);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        run       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        e_hc      = 8'd0;
        e_mc      = 8'd0;
        e_life    = 5;
        last_cell = 4'd0;
        cur       = 4'd0;
        repeat (2) @(posedge clk);
        test_reset();
        test_spawn();
        test_hits(1, "hit");
        test_miss("miss");
        test_wrong_key();
        test_expiry_match();
        test_hits(6, "hits_to_8");
        test_miss("miss_after_8");
        test_hits(300, "saturate");
        test_miss("miss_saturated");
        test_run_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
